// File: rtl/dmem_word_arbiter.sv
// dmem_word_arbiter: shares one byte-wide data memory port between two word
// requesters (port 0 = processor datapath, port 1 = loader/debug). Each 32-bit
// access is sequenced as four big-endian byte accesses (BYTE state), followed
// by a one-cycle completion pulse (DONE state).
// Optional build macro DMEM_ARB_FIXED_PRI_EN: when defined, port 0 always wins
// ties and the round-robin pointer is removed; otherwise ties alternate.
module dmem_word_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              gnt_id,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BYTE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // Latched request fields and read assembly; never observed outside BYTE,
  // so they carry no reset.
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [23:0]       asm_q, asm_d;

  logic any_req;
  logic win;

`ifndef DMEM_ARB_FIXED_PRI_EN
  logic rr_last_q, rr_last_d;
`endif

  // Pick the winning requester for the current IDLE edge
  always_comb begin
    any_req = req0_valid | req1_valid;
`ifdef DMEM_ARB_FIXED_PRI_EN
    // Processor port takes every tie; port 1 only wins when port 0 is idle.
    win = ~req0_valid;
`else
    // On a tie the port that did not win last time goes next.
    if (req0_valid && req1_valid) begin
      win = ~rr_last_q;
    end else begin
      win = ~req0_valid;
    end
`endif
  end

  // State register plus control flops with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      gnt_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifndef DMEM_ARB_FIXED_PRI_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifndef DMEM_ARB_FIXED_PRI_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  // Data-only registers: latched request and partial read word
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    asm_q   <= asm_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_BYTE;
      S_BYTE:  if (cnt_q == 2'd3) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant latching, byte counter and read-word assembly
  always_comb begin
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    asm_d    = asm_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifndef DMEM_ARB_FIXED_PRI_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = win;
          cnt_d   = 2'd0;
          we_d    = win ? req1_we    : req0_we;
          addr_d  = win ? req1_addr  : req0_addr;
          wdata_d = win ? req1_wdata : req0_wdata;
`ifndef DMEM_ARB_FIXED_PRI_EN
          rr_last_d = win;
`endif
        end
      end
      S_BYTE: begin
        cnt_d = cnt_q + 2'd1;
        asm_d = {asm_q[15:0], mem_rdata};
        // Last byte: publish the full word so it is visible with done.
        if (cnt_q == 2'd3 && !we_q) begin
          if (gnt_q) begin
            rdata1_d = {asm_q, mem_rdata};
          end else begin
            rdata0_d = {asm_q, mem_rdata};
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; mem_we falls with the async reset of state_q
  always_comb begin
    busy      = (state_q != S_IDLE);
    gnt_id    = gnt_q;
    done0     = (state_q == S_DONE) && !gnt_q;
    done1     = (state_q == S_DONE) &&  gnt_q;
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    if (state_q == S_BYTE) begin
      mem_we   = we_q;
      mem_addr = addr_q + ADDR_W'(cnt_q);
      case (cnt_q)
        2'd0:    mem_wdata = wdata_q[31:24];
        2'd1:    mem_wdata = wdata_q[23:16];
        2'd2:    mem_wdata = wdata_q[15:8];
        default: mem_wdata = wdata_q[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_word_arbiter.sv
// Self-checking bench for dmem_word_arbiter: directed word transfers, address
// wrap, reset mid-transfer, randomized single-port traffic and tie arbitration,
// all checked against a byte-array memory model and a per-port rdata model.
module tb_dmem_word_arbiter;

  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [31:0]   req0_wdata, req1_wdata;
  logic          done0, done1, busy, gnt_id, mem_we;
  logic [31:0]   rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  logic [7:0]  mem   [DEPTH];
  logic [7:0]  model [DEPTH];
  logic [31:0] exp_rdata [2];

  int total = 0;
  int bad   = 0;

  dmem_word_arbiter #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .done0(done0), .rdata0(rdata0),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .done1(done1), .rdata1(rdata1),
    .busy(busy), .gnt_id(gnt_id), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: synchronous write, combinational read
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [AW-1:0] a);
    logic [AW-1:0] i;
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      i = a + AW'(k);
      w = {w[23:0], model[i]};
    end
    return w;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {30'd0, done1, done0}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {27'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_gnt_id"}, {31'd0, gnt_id}, 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
  endtask

  // One word transaction on a single port; checks latency, strobe count,
  // completion pulse, rdata of both ports and the bytes written.
  task automatic run_txn(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [31:0] wd, input string tag);
    int cyc, wecnt, other;
    logic seen;
    logic [AW-1:0] idx;
    logic [31:0] obs_p, obs_o;
    @(negedge clk);
    if (p == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = wd;
    end
    cyc = 0; wecnt = 0; other = 0; seen = 1'b0;
    while (!seen && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (mem_we) wecnt++;
      if ((p == 0 && done1) || (p == 1 && done0)) other++;
      if ((p == 0 && done0) || (p == 1 && done1)) seen = 1'b1;
    end
    if (!seen) cyc = 99;
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        idx = a + AW'(k);
        model[idx] = wd[31-8*k -: 8];
      end
    end else begin
      exp_rdata[p] = model_word(a);
    end
    obs_p = (p == 0) ? rdata0 : rdata1;
    obs_o = (p == 0) ? rdata1 : rdata0;
    chk({tag, "_latency"}, cyc, 32'd5);
    chk({tag, "_we_cycles"}, wecnt, we ? 32'd4 : 32'd0);
    chk({tag, "_other_done"}, other, 32'd0);
    chk({tag, "_gnt_id"}, {31'd0, gnt_id}, p);
    chk({tag, "_rdata_own"}, obs_p, exp_rdata[p]);
    chk({tag, "_rdata_other"}, obs_o, exp_rdata[1-p]);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_len"}, {30'd0, done1, done0}, 32'd0);
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        idx = a + AW'(k);
        chk({tag, "_byte"}, {24'd0, mem[idx]}, {24'd0, model[idx]});
      end
    end
  endtask

  initial begin
    int cyc, who, exp_who;
    logic seen;
    logic [AW-1:0] a0, a1;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'($urandom);
      model[i] = mem[i];
    end
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed transfers, including address wrap at the top of memory
    run_txn(0, 1'b1, 5'd8, 32'hDEADBEEF, "p0_wr8");
    chk("p0_wr8_b8",  {24'd0, mem[8]},  32'hDE);
    chk("p0_wr8_b9",  {24'd0, mem[9]},  32'hAD);
    chk("p0_wr8_b10", {24'd0, mem[10]}, 32'hBE);
    chk("p0_wr8_b11", {24'd0, mem[11]}, 32'hEF);
    run_txn(0, 1'b0, 5'd8, 32'd0, "p0_rd8");
    chk("p0_rd8_word", rdata0, 32'hDEADBEEF);
    chk("p0_rd8_rdata1", rdata1, 32'd0);
    run_txn(1, 1'b1, 5'd30, 32'h11223344, "p1_wr30");
    chk("p1_wr30_b30", {24'd0, mem[30]}, 32'h11);
    chk("p1_wr30_b31", {24'd0, mem[31]}, 32'h22);
    chk("p1_wr30_b0",  {24'd0, mem[0]},  32'h33);
    chk("p1_wr30_b1",  {24'd0, mem[1]},  32'h44);
    run_txn(1, 1'b0, 5'd30, 32'd0, "p1_rd30");
    chk("p1_rd30_word", rdata1, 32'h11223344);

    // Reset pulsed during the third byte of a port 0 write
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 5'd4; req0_wdata = 32'hA1B2C3D4;
    repeat (3) @(negedge clk);
    chk("rstmid_addr_cnt2", {27'd0, mem_addr}, 32'd6);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    model[4] = 8'hA1;
    model[5] = 8'hB2;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_no_done", {30'd0, done1, done0}, 32'd0);
    chk("rstmid_b4", {24'd0, mem[4]}, 32'hA1);
    chk("rstmid_b5", {24'd0, mem[5]}, 32'hB2);
    chk("rstmid_b6", {24'd0, mem[6]}, {24'd0, model[6]});
    chk("rstmid_b7", {24'd0, mem[7]}, {24'd0, model[7]});
    run_txn(0, 1'b1, 5'd4, 32'h5A6B7C8D, "post_rst_wr");
    run_txn(0, 1'b0, 5'd4, 32'd0, "post_rst_rd");

    // Randomized single-port traffic against the memory model
    for (int n = 0; n < 24; n++) begin
      run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom), $urandom, "rand");
    end

    // Both ports continuously requesting reads straight out of reset
    rst_n = 1'b0;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    a0 = AW'($urandom);
    a1 = AW'($urandom);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = a0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = a1;
    for (int k = 0; k < 6; k++) begin
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 12) begin
        @(negedge clk);
        cyc++;
        if (done0 || done1) seen = 1'b1;
      end
      who = done1 ? 1 : 0;
`ifdef DMEM_ARB_FIXED_PRI_EN
      exp_who = 0;
`else
      exp_who = k % 2;
`endif
      chk("tie_seen", {31'd0, seen}, 32'd1);
      chk("tie_order", who, exp_who);
      chk("tie_gnt_id", {31'd0, gnt_id}, exp_who);
      exp_rdata[exp_who] = model_word(exp_who == 0 ? a0 : a1);
      chk("tie_rdata0", rdata0, exp_rdata[0]);
      chk("tie_rdata1", rdata1, exp_rdata[1]);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
